// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector: per-channel mode and FSM state.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_e;

endpackage

// File: rtl/edge_detector_multi_if.sv
// Signal bundle between the edge detector and its environment; state is a debug view of each channel FSM.
interface edge_detector_multi_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  // No handshake: every signal is a plain level, valid in every cycle and sampled at posedge clk.
  logic [WIDTH-1:0]       data_in;
  logic [2*WIDTH-1:0]     mode;
  logic [WIDTH-1:0]       clr;
  logic [WIDTH-1:0]       edge_det;
  logic [WIDTH-1:0]       edge_flag;
  logic [WIDTH*CNT_W-1:0] edge_cnt;
  logic                   any_flag;
  logic [WIDTH-1:0]       state;

  modport master (
    output data_in, mode, clr,
    input  edge_det, edge_flag, edge_cnt, any_flag, state
  );

  modport slave (
    input  data_in, mode, clr,
    output edge_det, edge_flag, edge_cnt, any_flag, state
  );
endinterface

// File: rtl/edge_detect_chan.sv
// One edge-detector channel: LOW/HIGH FSM, Mealy pulse, sticky flag, saturating counter.
// Optional input debounce when EDGE_DETECT_DEBOUNCE_EN is defined.
module edge_detect_chan
  import edge_detect_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int INIT_LEVEL   = 0,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  mode_e            mode,
  input  logic             clr,
  output logic             edge_det,
  output logic             edge_flag,
  output logic [CNT_W-1:0] edge_cnt,
  output state_e           state
);

  localparam state_e           RST_ST  = (INIT_LEVEL != 0) ? ST_HIGH : ST_LOW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ, accept;

  assign differ = (din != (state_q == ST_HIGH));

`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  logic [DB_W-1:0] db_q, db_d;

  // Accept in the DEBOUNCE_CYC-th consecutive differing cycle; the FSM move then clears the run.
  assign accept = differ && (db_q == DB_W'(DEBOUNCE_CYC - 1));

  always_comb begin
    db_d = '0;
    if (differ && !accept) db_d = db_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) db_q <= '0;
    else     db_q <= db_d;
  end
`else
  assign accept = differ;
`endif

  always_comb begin
    edge_det = 1'b0;
    case (mode)
      MODE_RISE: edge_det = accept && (state_q == ST_LOW);
      MODE_FALL: edge_det = accept && (state_q == ST_HIGH);
      MODE_BOTH: edge_det = accept;
      default:   edge_det = 1'b0;
    endcase
    if (rst) edge_det = 1'b0;

    state_d = state_q;
    if (accept) state_d = din ? ST_HIGH : ST_LOW;

    // Set wins over clear for the flag; clear wins over the edge for the count.
    flag_d = edge_det | (flag_q & ~clr);

    cnt_d = cnt_q;
    if (clr)                               cnt_d = '0;
    else if (edge_det && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_ST;
      flag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign edge_flag = flag_q;
  assign edge_cnt  = cnt_q;
  assign state     = state_q;

endmodule

// File: rtl/edge_detector_multi.sv
// WIDTH-channel Mealy edge detector with per-channel mode, sticky flags and saturating counts.
// Define EDGE_DETECT_DEBOUNCE_EN to add a DEBOUNCE_CYC-cycle input debounce per channel.
module edge_detector_multi
  import edge_detect_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 8,
  parameter int INIT_LEVEL   = 0,
  parameter int DEBOUNCE_CYC = 4
) (
  input logic                clk,
  input logic                rst,
  edge_detector_multi_if.slave bus
);

  logic [WIDTH-1:0]       det_w;
  logic [WIDTH-1:0]       flag_w;
  logic [WIDTH*CNT_W-1:0] cnt_w;
  logic [WIDTH-1:0]       state_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    state_e chan_state;

    edge_detect_chan #(
      .CNT_W        (CNT_W),
      .INIT_LEVEL   (INIT_LEVEL),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .din       (bus.data_in[i]),
      .mode      (mode_e'(bus.mode[2*i +: 2])),
      .clr       (bus.clr[i]),
      .edge_det  (det_w[i]),
      .edge_flag (flag_w[i]),
      .edge_cnt  (cnt_w[i*CNT_W +: CNT_W]),
      .state     (chan_state)
    );

    assign state_w[i] = (chan_state == ST_HIGH);
  end

  assign bus.edge_det  = det_w;
  assign bus.edge_flag = flag_w;
  assign bus.edge_cnt  = cnt_w;
  assign bus.any_flag  = |flag_w;
  assign bus.state     = state_w;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: directed scenarios plus randomized traffic against a behavioural model.
module tb_edge_detector_multi;

  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int INIT = 0;
  localparam int DBC  = 4;
`ifdef EDGE_DETECT_DEBOUNCE_EN
  localparam int DB = DBC;
`else
  localparam int DB = 1;
`endif
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_detector_multi_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  edge_detector_multi #(
    .WIDTH(W), .CNT_W(CW), .INIT_LEVEL(INIT), .DEBOUNCE_CYC(DBC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // lvl = last accepted level, run = consecutive cycles input has differed from it
  int lvl[W];
  int flg[W];
  int cnt[W];
  int run[W];

  logic [W-1:0]   cur_d = '0;
  logic [W-1:0]   cur_c = '0;
  logic [2*W-1:0] cur_m = '0;
  logic           cur_r = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit accepted(input int i);
    return (int'(cur_d[i]) != lvl[i]) && (run[i] + 1 >= DB);
  endfunction

  function automatic logic [W-1:0] model_det();
    logic [W-1:0] det = '0;
    for (int i = 0; i < W; i++) begin
      int m = int'(cur_m[2*i +: 2]);
      bit acc = accepted(i);
      case (m)
        0:       det[i] = acc && lvl[i] == 0;
        1:       det[i] = acc && lvl[i] == 1;
        2:       det[i] = acc;
        default: det[i] = 1'b0;
      endcase
    end
    if (cur_r) det = '0;
    return det;
  endfunction

  function automatic logic [W-1:0] vec_flag();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) v[i] = (flg[i] != 0);
    return v;
  endfunction

  function automatic logic [W*CW-1:0] vec_cnt();
    logic [W*CW-1:0] v = '0;
    for (int i = 0; i < W; i++) v[i*CW +: CW] = CW'(cnt[i]);
    return v;
  endfunction

  function automatic logic [W-1:0] vec_lvl();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) v[i] = (lvl[i] != 0);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] d, input logic [2*W-1:0] m,
                       input logic [W-1:0] c, input logic r);
    @(negedge clk);
    bus.data_in = d;
    bus.mode    = m;
    bus.clr     = c;
    rst         = r;
    cur_d = d; cur_m = m; cur_c = c; cur_r = r;
    #1;
    exp_q.push_back(model_det());
    check("edge_det", 64'(bus.edge_det), 64'(exp_q.pop_front()));
  endtask

  task automatic tick();
    logic [W-1:0] det;
    det = model_det();
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      if (cur_r) begin
        lvl[i] = INIT; flg[i] = 0; cnt[i] = 0; run[i] = 0;
      end else begin
        bit diff = (int'(cur_d[i]) != lvl[i]);
        bit acc  = accepted(i);
        flg[i] = (det[i] || (flg[i] != 0 && !cur_c[i])) ? 1 : 0;
        if (cur_c[i])    cnt[i] = 0;
        else if (det[i]) cnt[i] = (cnt[i] < CMAX) ? cnt[i] + 1 : cnt[i];
        if (acc) begin
          lvl[i] = int'(cur_d[i]); run[i] = 0;
        end else begin
          run[i] = diff ? run[i] + 1 : 0;
        end
      end
    end
    #1;
    check("edge_flag", 64'(bus.edge_flag), 64'(vec_flag()));
    check("edge_cnt",  64'(bus.edge_cnt),  64'(vec_cnt()));
    check("any_flag",  64'(bus.any_flag),  64'(|vec_flag()));
    check("state",     64'(bus.state),     64'(vec_lvl()));
  endtask

  task automatic hold(input logic [W-1:0] d, input logic [2*W-1:0] m,
                      input logic [W-1:0] c, input int n);
    repeat (n) begin
      drive(d, m, c, 1'b0);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.data_in = '0;
    bus.mode    = '0;
    bus.clr     = '0;

    // reset, all RISE, first rising edge on ch0
    repeat (2) begin
      drive('0, '0, '0, 1'b1);
      tick();
    end
    check("reset_flag", 64'(bus.edge_flag), 64'h0);
    check("reset_cnt",  64'(bus.edge_cnt),  64'h0);
    check("reset_any",  64'(bus.any_flag),  64'h0);
    hold(8'h01, '0, '0, DB - 1);
    drive(8'h01, '0, '0, 1'b0);
    check("t1_det", 64'(bus.edge_det), 64'h01);
    tick();
    check("t1_det_after", 64'(bus.edge_det), 64'h00);
    check("t1_flag", 64'(bus.edge_flag), 64'h01);
    check("t1_cnt0", 64'(bus.edge_cnt[7:0]), 64'd1);

    // ch1 FALL, ch2 BOTH
    hold(8'h07, 16'h0024, '0, DB);
    hold(8'h01, 16'h0024, '0, DB);
    check("t2_cnt1", 64'(bus.edge_cnt[15:8]),  64'd1);
    check("t2_cnt2", 64'(bus.edge_cnt[23:16]), 64'd2);

    // ch3 OFF toggled, then RISE while high
    for (int k = 0; k < 5; k++) hold((k % 2 == 0) ? 8'h09 : 8'h01, 16'h00C0, '0, DB);
    check("t3_cnt3_off", 64'(bus.edge_cnt[31:24]), 64'd0);
    hold(8'h09, '0, '0, DB);
    check("t3_cnt3_switch", 64'(bus.edge_cnt[31:24]), 64'd0);
    hold(8'h01, '0, '0, DB);
    hold(8'h09, '0, '0, DB);
    check("t3_cnt3_rise", 64'(bus.edge_cnt[31:24]), 64'd1);

    // saturation on ch0, then clr vs edge
    for (int k = 0; k < 300; k++) begin
      hold(8'h08, '0, '0, DB);
      hold(8'h09, '0, '0, DB);
    end
    check("t4_sat", 64'(bus.edge_cnt[7:0]), 64'd255);
    hold(8'h08, '0, '0, DB);
    hold(8'h09, '0, '0, DB - 1);
    drive(8'h09, '0, 8'h01, 1'b0);
    tick();
    check("t4_clr_edge_cnt",  64'(bus.edge_cnt[7:0]), 64'd0);
    check("t4_clr_edge_flag", 64'(bus.edge_flag[0]),  64'd1);
    drive(8'h09, '0, 8'h01, 1'b0);
    tick();
    check("t4_clr_flag", 64'(bus.edge_flag[0]), 64'd0);

    // reset in the middle of a ch4 pulse
    hold(8'h19, '0, '0, DB - 1);
    drive(8'h19, '0, '0, 1'b0);
    check("t5_det4", 64'(bus.edge_det[4]), 64'd1);
    rst   = 1'b1;
    cur_r = 1'b1;
    #1;
    check("t5_det_killed", 64'(bus.edge_det), 64'h0);
    tick();
    check("t5_flag",  64'(bus.edge_flag), 64'h0);
    check("t5_cnt",   64'(bus.edge_cnt),  64'h0);
    check("t5_state", 64'(bus.state),     64'h0);
    hold(8'h19, '0, '0, DB);
    check("t5_post_rst_cnt4", 64'(bus.edge_cnt[39:32]), 64'd1);

`ifdef EDGE_DETECT_DEBOUNCE_EN
    // short glitch on ch5 is ignored, a full hold is accepted once
    hold(8'h39, '0, '0, 3);
    hold(8'h19, '0, '0, 2);
    check("t6_glitch", 64'(bus.edge_cnt[47:40]), 64'd0);
    hold(8'h39, '0, '0, 3);
    drive(8'h39, '0, '0, 1'b0);
    check("t6_det5", 64'(bus.edge_det[5]), 64'd1);
    tick();
    check("t6_cnt5", 64'(bus.edge_cnt[47:40]), 64'd1);
`endif

    // randomized traffic
    begin
      logic [W-1:0]   d = 8'h19;
      logic [2*W-1:0] m = '0;
      for (int k = 0; k < 800; k++) begin
        logic [W-1:0] c;
        logic         r;
        if ($urandom_range(0, 5) == 0) d = W'($urandom);
        if ($urandom_range(0, 15) == 0) m = (2*W)'($urandom);
        c = W'($urandom & $urandom & $urandom);
        r = ($urandom_range(0, 99) == 0);
        drive(d, m, c, r);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
